// File: rtl/axis_buf_pkg.sv
// Shared constants and helpers for the AXI-Stream packet buffer.
package axis_buf_pkg;

   // Values accepted by the PACKET_MODE parameter
   localparam int unsigned MODE_CUT_THROUGH = 0;
   localparam int unsigned MODE_PACKET      = 1;

   // Width of a counter that must hold values 0..depth inclusive
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/axis_buf_ram.sv
// Beat storage: register array, one synchronous write port, one asynchronous read port.
module axis_buf_ram
   import axis_buf_pkg::*;
#(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Store the incoming beat; contents are deliberately not reset
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_packet_buffer.sv
// AXI-Stream circular FIFO with cut-through or store-and-forward presentation.
module axis_packet_buffer
   import axis_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned PACKET_MODE = 0
) (
   input  logic                         axis_aclk,
   input  logic                         axis_areset,
   input  logic [DATA_WIDTH-1:0]        s01_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]      s01_axis_tstrb,
   input  logic                         s01_axis_tvalid,
   input  logic                         s01_axis_tlast,
   output logic                         s01_axis_tready,
   input  logic                         m01_axis_tready,
   output logic [DATA_WIDTH-1:0]        m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]      m01_axis_tstrb,
   output logic                         m01_axis_tvalid,
   output logic                         m01_axis_tlast,
   output logic [$clog2(DEPTH+1)-1:0]   fill_level,
   output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
   output logic                         oversize_err
);

   localparam int unsigned SW = DATA_WIDTH / 8;
   localparam int unsigned WW = DATA_WIDTH + SW + 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] fill_q, fill_d;
   logic [CW-1:0] pkt_q, pkt_d;
   logic          release_q, release_d;
   logic          oversize_q, oversize_d;

   logic          s_ready;
   logic          m_valid;
   logic          wr_en, rd_en;
   logic          wr_last, rd_last;
   logic          head_last;
   logic          overflow_hit;
   logic [WW-1:0] wr_word, rd_word;

   // Modulo-DEPTH pointer advance; DEPTH need not be a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign s_ready   = !axis_areset && (fill_q < CW'(DEPTH));
   assign m_valid   = !axis_areset && (fill_q != '0) &&
                      ((PACKET_MODE == MODE_CUT_THROUGH) || (pkt_q != '0) || release_q);
   assign wr_en     = s01_axis_tvalid && s_ready;
   assign rd_en     = m_valid && m01_axis_tready;
   assign head_last = rd_word[0];
   assign wr_last   = wr_en && s01_axis_tlast;
   assign rd_last   = rd_en && head_last;

   // Full with no complete packet held: the packet can never complete in
   // store-and-forward, so it is released as cut-through and flagged.
   assign overflow_hit = (PACKET_MODE == MODE_PACKET) && (fill_q == CW'(DEPTH)) && (pkt_q == '0);

   assign wr_word = {s01_axis_tdata, s01_axis_tstrb, s01_axis_tlast};

   axis_buf_ram #(
      .WIDTH (WW),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clk_i     (axis_aclk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_word),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_word)
   );

   // Next-state for pointers, occupancy counters and release/error flags
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      pkt_d      = pkt_q;
      release_d  = release_q;
      oversize_d = oversize_q | overflow_hit;

      if (wr_en) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_en) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      case ({wr_en, rd_en})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase

      case ({wr_last, rd_last})
         2'b10:   pkt_d = pkt_q + 1'b1;
         2'b01:   pkt_d = pkt_q - 1'b1;
         default: pkt_d = pkt_q;
      endcase

      // overflow_hit implies no tlast is stored, so it cannot coincide with rd_last
      if (rd_last) begin
         release_d = 1'b0;
      end else if (overflow_hit) begin
         release_d = 1'b1;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         pkt_q      <= '0;
         release_q  <= 1'b0;
         oversize_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         pkt_q      <= pkt_d;
         release_q  <= release_d;
         oversize_q <= oversize_d;
      end
   end

   assign s01_axis_tready = s_ready;
   assign m01_axis_tvalid = m_valid;
   assign m01_axis_tdata  = m_valid ? rd_word[WW-1:SW+1] : '0;
   assign m01_axis_tstrb  = m_valid ? rd_word[SW:1]      : '0;
   assign m01_axis_tlast  = m_valid ? head_last          : 1'b0;
   assign fill_level      = fill_q;
   assign pkt_count       = pkt_q;
   assign oversize_err    = oversize_q;

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Directed self-checking bench: three buffer configurations share clock and reset.
module tb_axis_packet_buffer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Instance A: cut-through, DEPTH=8
   logic [31:0] a_s_tdata;  logic [3:0] a_s_tstrb;  logic a_s_tvalid, a_s_tlast, a_s_tready;
   logic [31:0] a_m_tdata;  logic [3:0] a_m_tstrb;  logic a_m_tvalid, a_m_tlast, a_m_tready;
   logic [3:0]  a_fill, a_pkt;  logic a_ovr;
   // Instance B: cut-through, DEPTH=5
   logic [31:0] b_s_tdata;  logic [3:0] b_s_tstrb;  logic b_s_tvalid, b_s_tlast, b_s_tready;
   logic [31:0] b_m_tdata;  logic [3:0] b_m_tstrb;  logic b_m_tvalid, b_m_tlast, b_m_tready;
   logic [2:0]  b_fill, b_pkt;  logic b_ovr;
   // Instance C: store-and-forward, DEPTH=4
   logic [31:0] c_s_tdata;  logic [3:0] c_s_tstrb;  logic c_s_tvalid, c_s_tlast, c_s_tready;
   logic [31:0] c_m_tdata;  logic [3:0] c_m_tstrb;  logic c_m_tvalid, c_m_tlast, c_m_tready;
   logic [2:0]  c_fill, c_pkt;  logic c_ovr;

   axis_packet_buffer #(.DATA_WIDTH(32), .DEPTH(8), .PACKET_MODE(0)) u_ct8 (
      .axis_aclk(clk), .axis_areset(rst),
      .s01_axis_tdata(a_s_tdata), .s01_axis_tstrb(a_s_tstrb), .s01_axis_tvalid(a_s_tvalid),
      .s01_axis_tlast(a_s_tlast), .s01_axis_tready(a_s_tready), .m01_axis_tready(a_m_tready),
      .m01_axis_tdata(a_m_tdata), .m01_axis_tstrb(a_m_tstrb), .m01_axis_tvalid(a_m_tvalid),
      .m01_axis_tlast(a_m_tlast), .fill_level(a_fill), .pkt_count(a_pkt), .oversize_err(a_ovr));

   axis_packet_buffer #(.DATA_WIDTH(32), .DEPTH(5), .PACKET_MODE(0)) u_ct5 (
      .axis_aclk(clk), .axis_areset(rst),
      .s01_axis_tdata(b_s_tdata), .s01_axis_tstrb(b_s_tstrb), .s01_axis_tvalid(b_s_tvalid),
      .s01_axis_tlast(b_s_tlast), .s01_axis_tready(b_s_tready), .m01_axis_tready(b_m_tready),
      .m01_axis_tdata(b_m_tdata), .m01_axis_tstrb(b_m_tstrb), .m01_axis_tvalid(b_m_tvalid),
      .m01_axis_tlast(b_m_tlast), .fill_level(b_fill), .pkt_count(b_pkt), .oversize_err(b_ovr));

   axis_packet_buffer #(.DATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(1)) u_pk4 (
      .axis_aclk(clk), .axis_areset(rst),
      .s01_axis_tdata(c_s_tdata), .s01_axis_tstrb(c_s_tstrb), .s01_axis_tvalid(c_s_tvalid),
      .s01_axis_tlast(c_s_tlast), .s01_axis_tready(c_s_tready), .m01_axis_tready(c_m_tready),
      .m01_axis_tdata(c_m_tdata), .m01_axis_tstrb(c_m_tstrb), .m01_axis_tvalid(c_m_tvalid),
      .m01_axis_tlast(c_m_tlast), .fill_level(c_fill), .pkt_count(c_pkt), .oversize_err(c_ovr));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] pat;
      int wr, rd, c;

      a_s_tdata = '0; a_s_tstrb = 4'hF; a_s_tvalid = 0; a_s_tlast = 0; a_m_tready = 0;
      b_s_tdata = '0; b_s_tstrb = 4'h3; b_s_tvalid = 0; b_s_tlast = 0; b_m_tready = 0;
      c_s_tdata = '0; c_s_tstrb = 4'hF; c_s_tvalid = 0; c_s_tlast = 0; c_m_tready = 0;

      // Reset held: both handshake outputs low
      repeat (3) tick();
      #1;
      chk("rst_s_tready", a_s_tready, 0);
      chk("rst_m_tvalid", a_m_tvalid, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_fill", a_fill, 0);
      chk("post_rst_pkt", a_pkt, 0);
      chk("post_rst_m_tvalid", a_m_tvalid, 0);
      chk("post_rst_s_tready", a_s_tready, 1);
      chk("post_rst_ovr", c_ovr, 0);

      // Single beat, one-cycle latency
      a_s_tdata = 32'h11111111; a_s_tlast = 1; a_s_tvalid = 1; a_m_tready = 1;
      #1;
      chk("lat_pre_valid", a_m_tvalid, 0);
      tick();
      a_s_tvalid = 0; a_s_tlast = 0;
      #1;
      chk("lat_valid", a_m_tvalid, 1);
      chk("lat_data", a_m_tdata, 32'h11111111);
      chk("lat_last", a_m_tlast, 1);
      chk("lat_strb", a_m_tstrb, 4'hF);
      chk("lat_fill1", a_fill, 1);
      tick();
      #1;
      chk("lat_fill0", a_fill, 0);
      chk("lat_empty_valid", a_m_tvalid, 0);
      chk("lat_gated_data", a_m_tdata, 0);

      // Fill to full, then stream through at full rate
      a_m_tready = 0;
      for (int i = 0; i < 8; i++) begin
         a_s_tdata = 32'hA0 + 32'(i); a_s_tvalid = 1;
         #1;
         tick();
      end
      #1;
      chk("full_fill", a_fill, 8);
      chk("full_s_tready", a_s_tready, 0);
      chk("full_head", a_m_tdata, 32'hA0);
      for (int k = 0; k < 20; k++) begin
         a_s_tdata  = (k == 0) ? 32'hC0 : 32'hC0 + 32'(k - 1);
         a_s_tvalid = 1; a_m_tready = 1;
         #1;
         chk("stream_head", a_m_tdata, (k < 8) ? 64'hA0 + 64'(k) : 64'hC0 + 64'(k - 8));
         chk("stream_fill", a_fill, (k == 0) ? 8 : 7);
         chk("stream_s_tready", a_s_tready, (k == 0) ? 0 : 1);
         tick();
      end
      a_s_tvalid = 0;
      for (int k = 0; k < 7; k++) begin
         #1;
         chk("drain_head", a_m_tdata, 64'hC0 + 64'(12 + k));
         tick();
      end
      #1;
      chk("drain_fill", a_fill, 0);
      a_m_tready = 0;

      // DEPTH=5 wrap-around with irregular downstream ready
      pat = 16'b1101_0110_0011_1011;
      wr = 0; rd = 0; c = 0;
      while (rd < 13 && c < 200) begin
         b_s_tvalid = (wr < 13);
         b_s_tdata  = 32'(wr);
         b_s_tlast  = (wr == 12);
         b_m_tready = pat[c % 16];
         #1;
         if (b_m_tvalid && b_m_tready) begin
            chk("wrap_data", b_m_tdata, 64'(rd));
            chk("wrap_last", b_m_tlast, (rd == 12) ? 1 : 0);
            chk("wrap_strb", b_m_tstrb, 4'h3);
            rd++;
         end
         if (b_s_tvalid && b_s_tready) wr++;
         tick();
         c++;
      end
      b_s_tvalid = 0; b_m_tready = 0;
      #1;
      chk("wrap_count", rd, 13);
      chk("wrap_fill", b_fill, 0);

      // Store-and-forward: nothing shown until tlast is stored
      c_m_tready = 1;
      for (int k = 0; k < 7; k++) begin
         c_s_tvalid = (k < 3);
         c_s_tdata  = 32'hB0 + 32'(k);
         c_s_tlast  = (k == 2);
         #1;
         chk("pkt_valid", c_m_tvalid, (k >= 3 && k <= 5) ? 1 : 0);
         chk("pkt_count", c_pkt, (k >= 3 && k <= 5) ? 1 : 0);
         if (k >= 3 && k <= 5) begin
            chk("pkt_data", c_m_tdata, 64'hB0 + 64'(k - 3));
            chk("pkt_last", c_m_tlast, (k == 5) ? 1 : 0);
         end
         tick();
      end
      #1;
      chk("pkt_fill", c_fill, 0);
      chk("pkt_ovr", c_ovr, 0);

      // Oversize packet (6 beats into DEPTH=4) released as cut-through
      wr = 0; rd = 0; c = 0;
      while (rd < 6 && c < 50) begin
         c_s_tvalid = (wr < 6);
         c_s_tdata  = 32'hD0 + 32'(wr);
         c_s_tlast  = (wr == 5);
         c_m_tready = 1;
         #1;
         if (c == 4) begin
            chk("ovr_full_fill", c_fill, 4);
            chk("ovr_full_valid", c_m_tvalid, 0);
            chk("ovr_before", c_ovr, 0);
         end
         if (c == 5) begin
            chk("ovr_set", c_ovr, 1);
            chk("ovr_release_valid", c_m_tvalid, 1);
         end
         if (c_m_tvalid && c_m_tready) begin
            chk("ovr_data", c_m_tdata, 64'hD0 + 64'(rd));
            chk("ovr_last", c_m_tlast, (rd == 5) ? 1 : 0);
            rd++;
         end
         if (c_s_tvalid && c_s_tready) wr++;
         tick();
         c++;
      end
      c_s_tvalid = 0;
      #1;
      chk("ovr_count", rd, 6);
      chk("ovr_sticky", c_ovr, 1);
      chk("ovr_fill", c_fill, 0);
      chk("ovr_pkt", c_pkt, 0);

      // Reset mid-packet discards buffered beats
      a_m_tready = 0;
      for (int i = 0; i < 3; i++) begin
         a_s_tdata = 32'hE0 + 32'(i); a_s_tvalid = 1; a_s_tlast = 0;
         #1;
         tick();
      end
      #1;
      chk("mid_fill3", a_fill, 3);
      rst = 1'b1;
      #1;
      chk("mid_rst_s_tready", a_s_tready, 0);
      chk("mid_rst_m_tvalid", a_m_tvalid, 0);
      chk("mid_rst_data", a_m_tdata, 0);
      tick();
      rst = 1'b0; a_s_tvalid = 0;
      #1;
      chk("mid_fill0", a_fill, 0);
      chk("mid_pkt0", a_pkt, 0);
      chk("mid_m_tvalid", a_m_tvalid, 0);
      chk("mid_s_tready", a_s_tready, 1);
      chk("mid_ovr_cleared", c_ovr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
